// File: rtl/pipeline_memd_stage8.sv
// -----------------------------------------------------------------------------
// pipeline_memd_stage8
//   Memory-data stage of the pipeline. It completes DRAM accesses, which take
//   a variable number of cycles and are bounded by a timeout, and system-bus
//   reads, which complete in a single cycle. Results are registered into the
//   *_MEMD outputs feeding writeback.
//
// Parameters
//   TIMEOUT_CYCLES   maximum number of WAIT_DRAM cycles before an access is
//                    aborted (legal range 2..255)
//
// Ports
//   clk, reset                 clock (rising edge); async active-high reset
//   stall                      global pipeline stall (includes memd_stall_req)
//   is_dram_MEMP               the MEMP access targets DRAM
//   pc_MEMP .. rd_MEMP         MEMP instruction fields, passed through to MEMD
//   dram_rd_ctrl/dram_wr_ctrl  nonzero = DRAM read/write pending
//   sys_bus_rd_ctrl            nonzero = bus read this cycle
//   dram_dout, dram_ready      DRAM read data and 1-cycle completion pulse
//   sys_bus_dout               bus read data (same cycle as sys_bus_rd_ctrl)
//   memd_stall_req             combinational request to stall the pipeline
//   mem_err_MEMD               1-cycle pulse when a DRAM access times out
//   pc_MEMD .. dm_dout_MEMD    registered results to writeback
// -----------------------------------------------------------------------------
module pipeline_memd_stage8 #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        is_dram_MEMP,
  input  logic [63:0] pc_MEMP,
  input  logic [1:0]  rf_wr_sel_MEMP,
  input  logic        rf_wr_en_MEMP,
  input  logic [63:0] alu_result_MEMP,
  input  logic [4:0]  rd_MEMP,
  input  logic [2:0]  dram_rd_ctrl,
  input  logic [2:0]  dram_wr_ctrl,
  input  logic [2:0]  sys_bus_rd_ctrl,
  input  logic [63:0] dram_dout,
  input  logic        dram_ready,
  input  logic [63:0] sys_bus_dout,
  output logic        memd_stall_req,
  output logic        mem_err_MEMD,
  output logic [63:0] pc_MEMD,
  output logic [1:0]  rf_wr_sel_MEMD,
  output logic        rf_wr_en_MEMD,
  output logic [63:0] alu_result_MEMD,
  output logic [4:0]  rd_MEMD,
  output logic [63:0] dm_dout_MEMD
);

  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    WAIT_DRAM
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  tcnt, tcnt_nxt;
  logic        buf_valid;
  logic [63:0] buf_data;
  logic        abort_pend;

  logic        dram_rd;
  logic        dram_pend;
  logic        abort_now;
  logic        aborted;
  logic [63:0] load_data;

  always_comb begin
    dram_rd   = (dram_rd_ctrl != 3'd0);
    dram_pend = (dram_rd || (dram_wr_ctrl != 3'd0)) && is_dram_MEMP;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // An access already resolved (buffered data or a latched abort) must not
  // re-enter WAIT_DRAM while an external stall keeps it sitting in MEMP.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    case (state)
      IDLE: begin
        if (dram_pend && !dram_ready && !buf_valid && !abort_pend) begin
          state_nxt = WAIT_DRAM;
          tcnt_nxt  = '0;
        end
      end
      WAIT_DRAM: begin
        if (dram_ready || abort_now) begin
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and load-data selection
  // An abort that happens under an external stall is latched in abort_pend so
  // the error is still reported when the pipeline advances.
  // ---------------------------------------------------------------------------
  always_comb begin
    abort_now      = (state == WAIT_DRAM) && (tcnt == TCNT_LAST) && !dram_ready;
    aborted        = abort_now || abort_pend;
    memd_stall_req = dram_pend && !dram_ready && !buf_valid && !aborted;

    load_data = '0;
    if (buf_valid) begin
      load_data = buf_data;
    end else if (dram_pend) begin
      // writes return zero; an aborted read returns zero
      if (dram_rd && !aborted) begin
        load_data = dram_dout;
      end
    end else if (sys_bus_rd_ctrl != 3'd0) begin
      load_data = sys_bus_dout;
    end
  end

  // ---------------------------------------------------------------------------
  // Completion buffer and MEMD registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid       <= 1'b0;
      buf_data        <= '0;
      abort_pend      <= 1'b0;
      mem_err_MEMD    <= 1'b0;
      pc_MEMD         <= '0;
      rf_wr_sel_MEMD  <= '0;
      rf_wr_en_MEMD   <= 1'b0;
      alu_result_MEMD <= '0;
      rd_MEMD         <= '0;
      dm_dout_MEMD    <= '0;
    end else if (stall) begin
      // a completion seen while stalled is kept until the stage advances
      if (dram_pend && dram_ready && !buf_valid && !abort_pend) begin
        buf_valid <= 1'b1;
        buf_data  <= dram_rd ? dram_dout : '0;
      end
      if (abort_now) begin
        abort_pend <= 1'b1;
      end
      mem_err_MEMD <= 1'b0;
    end else begin
      buf_valid       <= 1'b0;
      abort_pend      <= 1'b0;
      mem_err_MEMD    <= aborted;
      pc_MEMD         <= pc_MEMP;
      rf_wr_sel_MEMD  <= rf_wr_sel_MEMP;
      rf_wr_en_MEMD   <= rf_wr_en_MEMP && !aborted;
      alu_result_MEMD <= alu_result_MEMP;
      rd_MEMD         <= rd_MEMP;
      dm_dout_MEMD    <= load_data;
    end
  end

endmodule

// File: tb/tb_pipeline_memd_stage8.sv
// -----------------------------------------------------------------------------
// tb_pipeline_memd_stage8
//   Self-checking bench for pipeline_memd_stage8 (TIMEOUT_CYCLES = 4).
//   Single-cycle accesses come from a vector table; DRAM latency, buffered
//   completion, timeout and reset-during-wait are hand-written sequences.
//   Expected MEMD contents are queued when an advancing cycle is driven and
//   compared after the following clock edge.
// -----------------------------------------------------------------------------
module tb_pipeline_memd_stage8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ext_stall;
  logic        stall;
  logic        is_dram_MEMP;
  logic [63:0] pc_MEMP;
  logic [1:0]  rf_wr_sel_MEMP;
  logic        rf_wr_en_MEMP;
  logic [63:0] alu_result_MEMP;
  logic [4:0]  rd_MEMP;
  logic [2:0]  dram_rd_ctrl;
  logic [2:0]  dram_wr_ctrl;
  logic [2:0]  sys_bus_rd_ctrl;
  logic [63:0] dram_dout;
  logic        dram_ready;
  logic [63:0] sys_bus_dout;
  logic        memd_stall_req;
  logic        mem_err_MEMD;
  logic [63:0] pc_MEMD;
  logic [1:0]  rf_wr_sel_MEMD;
  logic        rf_wr_en_MEMD;
  logic [63:0] alu_result_MEMD;
  logic [4:0]  rd_MEMD;
  logic [63:0] dm_dout_MEMD;

  // the global stall always includes this stage's own request
  assign stall = ext_stall | memd_stall_req;

  always #5 clk = ~clk;

  pipeline_memd_stage8 #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .is_dram_MEMP    (is_dram_MEMP),
    .pc_MEMP         (pc_MEMP),
    .rf_wr_sel_MEMP  (rf_wr_sel_MEMP),
    .rf_wr_en_MEMP   (rf_wr_en_MEMP),
    .alu_result_MEMP (alu_result_MEMP),
    .rd_MEMP         (rd_MEMP),
    .dram_rd_ctrl    (dram_rd_ctrl),
    .dram_wr_ctrl    (dram_wr_ctrl),
    .sys_bus_rd_ctrl (sys_bus_rd_ctrl),
    .dram_dout       (dram_dout),
    .dram_ready      (dram_ready),
    .sys_bus_dout    (sys_bus_dout),
    .memd_stall_req  (memd_stall_req),
    .mem_err_MEMD    (mem_err_MEMD),
    .pc_MEMD         (pc_MEMD),
    .rf_wr_sel_MEMD  (rf_wr_sel_MEMD),
    .rf_wr_en_MEMD   (rf_wr_en_MEMD),
    .alu_result_MEMD (alu_result_MEMD),
    .rd_MEMD         (rd_MEMD),
    .dm_dout_MEMD    (dm_dout_MEMD)
  );

  typedef struct {
    logic [63:0] pc;
    logic [1:0]  sel;
    logic        wen;
    logic [63:0] alu;
    logic [4:0]  rd;
    logic [63:0] dout;
    logic        err;
  } exp_t;

  typedef struct {
    logic [63:0] pc;
    logic [1:0]  sel;
    logic        wen;
    logic [63:0] alu;
    logic [4:0]  rd;
    logic [2:0]  bus_rd;
    logic [63:0] bus_dout;
    logic        is_dram;
    logic [2:0]  drd;
    logic [2:0]  dwr;
    logic [63:0] ddout;
    logic        dready;
    logic [63:0] exp_dout;
    logic        exp_req;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];
  exp_t exp_q[$];
  exp_t last;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_regs(input exp_t e);
    chk("pc_MEMD",         pc_MEMD,              e.pc);
    chk("rf_wr_sel_MEMD",  64'(rf_wr_sel_MEMD),  64'(e.sel));
    chk("rf_wr_en_MEMD",   64'(rf_wr_en_MEMD),   64'(e.wen));
    chk("alu_result_MEMD", alu_result_MEMD,      e.alu);
    chk("rd_MEMD",         64'(rd_MEMD),         64'(e.rd));
    chk("dm_dout_MEMD",    dm_dout_MEMD,         e.dout);
    chk("mem_err_MEMD",    64'(mem_err_MEMD),    64'(e.err));
  endtask

  function automatic exp_t mk(input logic [63:0] pc, input logic [1:0] sel, input logic wen,
                              input logic [63:0] alu, input logic [4:0] rd,
                              input logic [63:0] dout, input logic err);
    exp_t e;
    e.pc = pc; e.sel = sel; e.wen = wen; e.alu = alu; e.rd = rd; e.dout = dout; e.err = err;
    return e;
  endfunction

  task automatic clear_inputs();
    ext_stall       = 1'b0;
    is_dram_MEMP    = 1'b0;
    pc_MEMP         = '0;
    rf_wr_sel_MEMP  = '0;
    rf_wr_en_MEMP   = 1'b0;
    alu_result_MEMP = '0;
    rd_MEMP         = '0;
    dram_rd_ctrl    = '0;
    dram_wr_ctrl    = '0;
    sys_bus_rd_ctrl = '0;
    dram_dout       = '0;
    dram_ready      = 1'b0;
    sys_bus_dout    = '0;
  endtask

  task automatic set_pass(input logic [63:0] pc, input logic [1:0] sel, input logic wen,
                          input logic [63:0] alu, input logic [4:0] rd);
    pc_MEMP = pc; rf_wr_sel_MEMP = sel; rf_wr_en_MEMP = wen; alu_result_MEMP = alu; rd_MEMP = rd;
  endtask

  // Called at a negedge with inputs already driven: checks the stall request,
  // optionally queues the expected MEMD result, then checks MEMD after the edge.
  // Without a queued result the registers must hold with mem_err low.
  task automatic tick(input bit push, input exp_t e, input logic exp_req);
    exp_t h;
    #1;
    chk("memd_stall_req", 64'(memd_stall_req), 64'(exp_req));
    if (push) exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      last = exp_q.pop_front();
      chk_regs(last);
    end else begin
      h = last;
      h.err = 1'b0;
      chk_regs(h);
    end
  endtask

  exp_t zero_e;
  exp_t none_e;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    zero_e = mk('0, '0, 1'b0, '0, '0, '0, 1'b0);
    none_e = zero_e;
    last   = zero_e;

    vecs[0] = '{64'h100, 2'd1, 1'b1, 64'h40, 5'd5, 3'b011, 64'hDEAD, 1'b0, 3'd0, 3'd0, 64'h0, 1'b0, 64'hDEAD, 1'b0};
    vecs[1] = '{64'h104, 2'd0, 1'b0, 64'h44, 5'd0, 3'b000, 64'hFFFF, 1'b0, 3'd0, 3'd0, 64'h0, 1'b0, 64'h0, 1'b0};
    vecs[2] = '{64'h108, 2'd3, 1'b0, 64'h48, 5'd31, 3'b100, 64'h0123456789ABCDEF, 1'b0, 3'd0, 3'd0, 64'h0, 1'b0, 64'h0123456789ABCDEF, 1'b0};
    vecs[3] = '{64'h10C, 2'd2, 1'b1, 64'h4C, 5'd1, 3'b000, 64'h0, 1'b0, 3'd1, 3'd0, 64'hAAAA, 1'b0, 64'h0, 1'b0};
    vecs[4] = '{64'h110, 2'd1, 1'b1, 64'h50, 5'd2, 3'b001, 64'h5555, 1'b0, 3'd2, 3'd0, 64'hAAAA, 1'b0, 64'h5555, 1'b0};
    vecs[5] = '{64'h114, 2'd0, 1'b1, 64'h54, 5'd3, 3'b000, 64'h0, 1'b0, 3'd0, 3'd0, 64'hBBBB, 1'b1, 64'h0, 1'b0};
    vecs[6] = '{64'h118, 2'd1, 1'b1, 64'h58, 5'd4, 3'b000, 64'h0, 1'b1, 3'd1, 3'd0, 64'hCAFE, 1'b1, 64'hCAFE, 1'b0};
    vecs[7] = '{64'h11C, 2'd0, 1'b0, 64'h5C, 5'd6, 3'b010, 64'h7777, 1'b1, 3'd0, 3'd1, 64'hCAFE, 1'b1, 64'h0, 1'b0};
    vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 3'b111,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd0, 3'd0, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

    // reset state
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    chk_regs(zero_e);
    chk("memd_stall_req", 64'(memd_stall_req), 64'd0);
    reset = 1'b0;

    // single-cycle accesses
    for (int i = 0; i < NV; i++) begin
      set_pass(vecs[i].pc, vecs[i].sel, vecs[i].wen, vecs[i].alu, vecs[i].rd);
      sys_bus_rd_ctrl = vecs[i].bus_rd;
      sys_bus_dout    = vecs[i].bus_dout;
      is_dram_MEMP    = vecs[i].is_dram;
      dram_rd_ctrl    = vecs[i].drd;
      dram_wr_ctrl    = vecs[i].dwr;
      dram_dout       = vecs[i].ddout;
      dram_ready      = vecs[i].dready;
      tick(1'b1, mk(vecs[i].pc, vecs[i].sel, vecs[i].wen, vecs[i].alu, vecs[i].rd,
                    vecs[i].exp_dout, 1'b0), vecs[i].exp_req);
    end

    // DRAM read, ready arrives in cycle 3
    clear_inputs();
    set_pass(64'h200, 2'd1, 1'b1, 64'h300, 5'd7);
    is_dram_MEMP = 1'b1;
    dram_rd_ctrl = 3'd1;
    for (int c = 0; c < 3; c++) tick(1'b0, none_e, 1'b1);
    dram_ready = 1'b1;
    dram_dout  = 64'h1234;
    tick(1'b1, mk(64'h200, 2'd1, 1'b1, 64'h300, 5'd7, 64'h1234, 1'b0), 1'b0);
    clear_inputs();
    tick(1'b1, zero_e, 1'b0);

    // DRAM read completing under an external stall
    set_pass(64'h210, 2'd2, 1'b1, 64'h310, 5'd8);
    is_dram_MEMP = 1'b1;
    dram_rd_ctrl = 3'd2;
    tick(1'b0, none_e, 1'b1);
    ext_stall  = 1'b1;
    dram_ready = 1'b1;
    dram_dout  = 64'hBEEF;
    tick(1'b0, none_e, 1'b0);
    dram_ready = 1'b0;
    dram_dout  = 64'h0;
    tick(1'b0, none_e, 1'b0);
    ext_stall = 1'b0;
    tick(1'b1, mk(64'h210, 2'd2, 1'b1, 64'h310, 5'd8, 64'hBEEF, 1'b0), 1'b0);
    clear_inputs();
    tick(1'b1, zero_e, 1'b0);

    // DRAM write, ready one cycle late: load data is zero
    set_pass(64'h220, 2'd0, 1'b0, 64'h320, 5'd9);
    is_dram_MEMP = 1'b1;
    dram_wr_ctrl = 3'd3;
    tick(1'b0, none_e, 1'b1);
    dram_ready = 1'b1;
    dram_dout  = 64'h9999;
    tick(1'b1, mk(64'h220, 2'd0, 1'b0, 64'h320, 5'd9, 64'h0, 1'b0), 1'b0);
    clear_inputs();
    tick(1'b1, zero_e, 1'b0);

    // timeout: four stalled cycles, then abort with a single error pulse
    set_pass(64'h230, 2'd1, 1'b1, 64'h330, 5'd10);
    is_dram_MEMP = 1'b1;
    dram_rd_ctrl = 3'd1;
    dram_dout    = 64'h77;
    for (int c = 0; c < 4; c++) tick(1'b0, none_e, 1'b1);
    tick(1'b1, mk(64'h230, 2'd1, 1'b0, 64'h330, 5'd10, 64'h0, 1'b1), 1'b0);
    clear_inputs();
    tick(1'b1, zero_e, 1'b0);

    // reset in the middle of a DRAM wait, then a stray ready
    set_pass(64'h240, 2'd3, 1'b1, 64'h340, 5'd11);
    sys_bus_rd_ctrl = 3'd1;
    sys_bus_dout    = 64'h66;
    tick(1'b1, mk(64'h240, 2'd3, 1'b1, 64'h340, 5'd11, 64'h66, 1'b0), 1'b0);
    clear_inputs();
    set_pass(64'h250, 2'd1, 1'b1, 64'h350, 5'd12);
    is_dram_MEMP = 1'b1;
    dram_rd_ctrl = 3'd1;
    for (int c = 0; c < 3; c++) tick(1'b0, none_e, 1'b1);
    reset = 1'b1;
    clear_inputs();
    #1;
    chk_regs(zero_e);
    chk("memd_stall_req", 64'(memd_stall_req), 64'd0);
    last = zero_e;
    @(negedge clk);
    reset      = 1'b0;
    dram_ready = 1'b1;
    dram_dout  = 64'hF00D;
    tick(1'b1, zero_e, 1'b0);
    dram_ready = 1'b0;
    dram_dout  = 64'h0;
    tick(1'b1, zero_e, 1'b0);
    // a fresh read with same-cycle ready proceeds normally after reset
    set_pass(64'h260, 2'd2, 1'b1, 64'h360, 5'd13);
    is_dram_MEMP = 1'b1;
    dram_rd_ctrl = 3'd4;
    dram_ready   = 1'b1;
    dram_dout    = 64'h42;
    tick(1'b1, mk(64'h260, 2'd2, 1'b1, 64'h360, 5'd13, 64'h42, 1'b0), 1'b0);
    clear_inputs();
    tick(1'b1, zero_e, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_memd_stage8.md
PIPELINE_MEMD_STAGE8 -- requirements
Module: pipeline_memd_stage8

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, max WAIT_DRAM cycles before an access is aborted (legal range 2..255).
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall  in  1  global pipeline stall; it already includes memd_stall_req.
- is_dram_MEMP  in  1  the access in MEMP targets DRAM.
- pc_MEMP  in  64  PC of the MEMP instruction.
- rf_wr_sel_MEMP  in  2  writeback select, passed through.
- rf_wr_en_MEMP  in  1  register-file write enable.
- alu_result_MEMP  in  64  ALU result / address, passed through.
- rd_MEMP  in  5  destination register.
- dram_rd_ctrl  in  3  registered DRAM read control; nonzero means read pending.
- dram_wr_ctrl  in  3  registered DRAM write control; nonzero means write pending.
- sys_bus_rd_ctrl  in  3  registered bus read control; nonzero means bus read.
- dram_dout  in  64  DRAM read data; valid when dram_ready=1.
- dram_ready  in  1  DRAM completion, 1-cycle pulse per access.
- sys_bus_dout  in  64  bus read data; valid in the same cycle as sys_bus_rd_ctrl.
- memd_stall_req  out  1  combinational request to stall the whole pipeline.
- mem_err_MEMD  out  1  1-cycle registered pulse on DRAM timeout.
- pc_MEMD, rf_wr_sel_MEMD, rf_wr_en_MEMD, alu_result_MEMD, rd_MEMD  out  64/2/1/64/5  registered pass-through to WB.
- dm_dout_MEMD  out  64  registered load data to WB.

Function
REQ-003 SHALL define dram_pend = (dram_rd_ctrl!=0 || dram_wr_ctrl!=0) && is_dram_MEMP.
REQ-004 SHALL implement an FSM with states IDLE and WAIT_DRAM and a timeout counter tcnt (8 bits).
REQ-005 In IDLE with dram_pend=1, dram_ready=0 and buf_valid=0, the block SHALL go to WAIT_DRAM and set tcnt=0.
REQ-006 In WAIT_DRAM with dram_ready=0, the block SHALL increment tcnt each cycle.
REQ-007 In WAIT_DRAM, when dram_ready=1, the block SHALL return to IDLE.
REQ-008 In WAIT_DRAM, when tcnt==TIMEOUT_CYCLES-1 and dram_ready=0, the block SHALL abort: return to IDLE and set the timeout flag.
REQ-009 memd_stall_req SHALL equal dram_pend && !dram_ready && !buf_valid && !abort_now, in both states.
- abort_now is the REQ-008 timeout condition.
- A same-cycle dram_ready therefore never stalls.
REQ-010 SHALL keep a 64-bit data buffer buf_data with flag buf_valid.
- Set, capturing dram_dout, when dram_ready=1 while stall=1.
- Cleared on any cycle with stall=0.
REQ-011 Load data SHALL be selected with this priority:
- buf_valid: buf_data.
- else dram_pend with dram_rd_ctrl!=0: dram_dout, or 0 on abort.
- else sys_bus_rd_ctrl!=0: sys_bus_dout.
- else 0.
REQ-012 On stall=0, all *_MEMD registers SHALL load from their *_MEMP sources and the REQ-011 data; on stall=1 they SHALL hold.
REQ-013 On an aborted access, rf_wr_en_MEMD SHALL load 0 and mem_err_MEMD SHALL be 1 for exactly one cycle.
- Otherwise mem_err_MEMD SHALL be 0.
REQ-014 DRAM writes SHALL use the same stall/ready/timeout handling as reads; dm_dout_MEMD SHALL load 0 for writes.
REQ-015 A dram_ready seen in IDLE without dram_pend SHALL be ignored.
REQ-016 Latency SHALL be:
- Bus access or no access: 1 cycle, never stalls.
- DRAM access: 1 cycle after dram_ready, or 1 cycle after abort.

Reset
REQ-017 On reset=1 (asynchronous), all outputs SHALL be 0, state SHALL be IDLE, and tcnt=0, buf_valid=0, buf_data=0.
REQ-018 Reset asserted mid-WAIT_DRAM SHALL discard the pending access; a later stray dram_ready SHALL be ignored per REQ-015.

Verification
REQ-019 Bus load: sys_bus_rd_ctrl=3'b011, sys_bus_dout=64'hDEAD, rd_MEMP=5, stall=0 -> next cycle dm_dout_MEMD=64'hDEAD, rd_MEMD=5, memd_stall_req never 1.
REQ-020 DRAM read, ready 3 cycles late: dram_rd_ctrl=1, is_dram_MEMP=1, dram_ready pulse at cycle 3 with dram_dout=64'h1234 -> memd_stall_req=1 for cycles 0-2; dm_dout_MEMD=64'h1234 at cycle 4.
REQ-021 Ready under external stall: dram_ready with 64'hBEEF while stall=1, stall released 2 cycles later -> buf_valid=1, memd_stall_req=0, dm_dout_MEMD=64'hBEEF after release.
REQ-022 Timeout: TIMEOUT_CYCLES=4, dram_ready never asserted -> after 4 stalled cycles, mem_err_MEMD pulses once, rf_wr_en_MEMD=0, dm_dout_MEMD=0.
REQ-023 Reset mid-wait: reset at WAIT_DRAM cycle 2, dram_ready pulse after release with no dram_pend -> all outputs 0, memd_stall_req=0.
